ks16_wide_add_seq: RTL and testbench

- Sequencer that performs multi-word (wide) addition and subtraction over a stream of 16-bit operand word pairs, least-significant word first.
- Each accepted word pair goes to a 16-bit Kogge-Stone core with carry-in. Carry-out is chained to the next word.
- Registered sum words go out on a valid/ready stream.
- Sits directly upstream and downstream of the 16-bit Kogge-Stone adder core: feeds its X/Y/Cin and captures its 17-bit result.

---
 rtl/ks16_pkg.sv | 12 +
 rtl/ks16_core_cin.sv | 43 ++++
 rtl/ks16_wide_add_seq.sv | 139 +++++++++++++
 tb/tb_ks16_wide_add_seq.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ks16_pkg.sv
// Shared constants and types for the 16-bit Kogge-Stone wide add/sub sequencer.
package ks16_pkg;

    localparam int WORD_W        = 16;
    localparam int MAX_WORDS_DEF = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/ks16_core_cin.sv
// 16-bit Kogge-Stone adder with carry-in; purely combinational, 17-bit result.
module ks16_core_cin
    import ks16_pkg::*;
(
    input  logic [WORD_W-1:0] x,
    input  logic [WORD_W-1:0] y,
    input  logic              cin,
    output logic [WORD_W:0]   s
);

    // Carry-in is folded into the bit-0 generate so the prefix tree yields carries directly.
    function automatic logic [WORD_W:0] ks_add(input logic [WORD_W-1:0] a,
                                               input logic [WORD_W-1:0] b,
                                               input logic              c);
        logic [WORD_W-1:0] pr;
        logic [WORD_W-1:0] g;
        logic [WORD_W-1:0] p;
        logic [WORD_W-1:0] g_n;
        logic [WORD_W-1:0] p_n;
        pr   = a ^ b;
        g    = a & b;
        g[0] = g[0] | (pr[0] & c);
        p    = pr;
        for (int d = 1; d < WORD_W; d = d * 2) begin
            // NOTE: blocking assignments here are intentional; each prefix stage must
            // see the fully updated values of the previous stage within the same evaluation.
            g_n = g;
            p_n = p;
            for (int i = d; i < WORD_W; i++) begin
                g_n[i] = g[i] | (p[i] & g[i-d]);
                p_n[i] = p[i] & p[i-d];
            end
            g = g_n;
            p = p_n;
        end
        return {g[WORD_W-1], pr[WORD_W-1:1] ^ g[WORD_W-2:0], pr[0] ^ c};
    endfunction

    always_comb begin
        s = ks_add(x, y, cin);
    end

endmodule

// File: rtl/ks16_wide_add_seq.sv
// Multi-word add/sub sequencer: streams LSW-first word pairs through the KS core, chains carry.
module ks16_wide_add_seq
    import ks16_pkg::*;
#(
    parameter int MAX_WORDS = MAX_WORDS_DEF,
    parameter int IDX_W     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_x,
    input  logic [WORD_W-1:0] in_y,
    input  logic              in_first,
    input  logic              in_last,
    input  logic              in_sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_sum,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              out_cout,
    output logic              err_proto,
    output logic              err_len,
    input  logic              err_clr
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_carry;
    logic              r_sub;
    logic [IDX_W-1:0]  r_idx;
    logic              r_valid;
    logic [WORD_W-1:0] r_sum;
    logic              r_last;
    logic              r_cout;
    logic              r_err_proto;
    logic              r_err_len;

    logic              w_in_fire;
    logic              w_first;
    logic              w_sub;
    logic              w_cin;
    logic [WORD_W-1:0] w_y;
    logic [WORD_W:0]   w_s;
    logic [IDX_W-1:0]  w_idx;
    logic              w_force;
    logic              w_last;
    logic              w_ev_proto;

    // Gating with rst_n keeps the input closed while reset is held.
    assign in_ready  = rst_n & (~r_valid | out_ready);
    assign w_in_fire = in_valid & in_ready;

    // Any word accepted in IDLE starts a new operation, as does a first word mid-RUN.
    assign w_first    = (r_state == IDLE) | in_first;
    assign w_sub      = w_first ? in_sub : r_sub;
    assign w_cin      = w_first ? in_sub : r_carry;
    assign w_y        = w_sub ? ~in_y : in_y;
    assign w_idx      = w_first ? '0 : r_idx + IDX_W'(1);
    assign w_force    = ~in_last & (w_idx == IDX_W'(MAX_WORDS - 1));
    assign w_last     = in_last | w_force;
    assign w_ev_proto = w_in_fire & (r_state == RUN) & in_first;

    ks16_core_cin u_core (
        .x   (in_x),
        .y   (w_y),
        .cin (w_cin),
        .s   (w_s)
    );

    always_comb begin
        // NOTE: default first so every path assigns the next state and no latch is inferred.
        w_state_nxt = r_state;
        if (w_in_fire) begin
            w_state_nxt = w_last ? IDLE : RUN;
        end
    end

    // NOTE: state uses non-blocking assignments with async active-low reset; all
    // registers here are plain flops, so each gets an explicit reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry <= 1'b0;
            r_sub   <= 1'b0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_sum   <= '0;
            r_last  <= 1'b0;
            r_cout  <= 1'b0;
        end else if (w_in_fire) begin
            r_carry <= w_s[WORD_W];
            r_sub   <= w_sub;
            r_idx   <= w_idx;
            r_valid <= 1'b1;
            r_sum   <= w_s[WORD_W-1:0];
            r_last  <= w_last;
            r_cout  <= w_last & w_s[WORD_W];
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Sticky flags: a new error event wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_proto <= 1'b0;
            r_err_len   <= 1'b0;
        end else begin
            if (w_ev_proto) begin
                r_err_proto <= 1'b1;
            end else if (err_clr) begin
                r_err_proto <= 1'b0;
            end
            if (w_in_fire & w_force) begin
                r_err_len <= 1'b1;
            end else if (err_clr) begin
                r_err_len <= 1'b0;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_sum   = r_sum;
    assign out_idx   = r_idx;
    assign out_last  = r_last;
    assign out_cout  = r_cout;
    assign err_proto = r_err_proto;
    assign err_len   = r_err_len;

endmodule

// File: tb/tb_ks16_wide_add_seq.sv
// Scoreboard bench for ks16_wide_add_seq: behavioural word model feeds a queue, monitor pops on drain.
module tb_ks16_wide_add_seq;

    localparam int MAXW = 8;
    localparam int IDXW = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_x = '0;
    logic [15:0] in_y = '0;
    logic        in_first = 1'b0;
    logic        in_last = 1'b0;
    logic        in_sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_sum;
    logic [IDXW-1:0] out_idx;
    logic        out_last;
    logic        out_cout;
    logic        err_proto;
    logic        err_len;
    logic        err_clr = 1'b0;

    typedef struct packed {
        logic [15:0]     sum;
        logic [IDXW-1:0] idx;
        logic            last;
        logic            cout;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state for the word stream.
    bit            m_run   = 0;
    bit            m_carry = 0;
    bit            m_sub   = 0;
    logic [IDXW-1:0] m_idx = '0;

    exp_t mon_e;
    exp_t mon_a;

    ks16_wide_add_seq #(.MAX_WORDS(MAXW), .IDX_W(IDXW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_first  (in_first),
        .in_last   (in_last),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_cout  (out_cout),
        .err_proto (err_proto),
        .err_len   (err_len),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Inputs change at posedge+1, so at negedge a valid&ready pair means a drain at the next edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            mon_a = {out_sum, out_idx, out_last, out_cout};
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL out_word: unexpected word sum=%h idx=%0d last=%b cout=%b, expected none",
                         out_sum, out_idx, out_last, out_cout);
            end else begin
                mon_e = q.pop_front();
                if (mon_a !== mon_e) begin
                    bad++;
                    $display("FAIL out_word: got sum=%h idx=%0d last=%b cout=%b, expected sum=%h idx=%0d last=%b cout=%b",
                             out_sum, out_idx, out_last, out_cout,
                             mon_e.sum, mon_e.idx, mon_e.last, mon_e.cout);
                end
            end
        end
    end

    task automatic send(input logic [15:0] x, input logic [15:0] y,
                        input logic first, input logic last, input logic sub, input logic rdy);
        logic [16:0]     r;
        logic [15:0]     yy;
        logic            fm;
        logic            se;
        logic            ci;
        logic            lst;
        logic [IDXW-1:0] ix;
        @(posedge clk);
        #1;
        in_x      = x;
        in_y      = y;
        in_first  = first;
        in_last   = last;
        in_sub    = sub;
        out_ready = rdy;
        in_valid  = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) begin
                fm  = !m_run || first;
                se  = fm ? sub : m_sub;
                ci  = fm ? sub : m_carry;
                yy  = se ? ~y : y;
                r   = {1'b0, x} + {1'b0, yy} + {16'd0, ci};
                ix  = fm ? '0 : m_idx + 1'b1;
                lst = last || (ix == IDXW'(MAXW - 1));
                q.push_back({r[15:0], ix, lst, lst & r[16]});
                m_run   = !lst;
                m_carry = r[16];
                m_sub   = se;
                m_idx   = ix;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                in_first = 1'b0;
                in_last  = 1'b0;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL send_timeout: in_ready=0 for 50 cycles, expected 1");
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({out_valid, out_sum, out_idx, out_last, out_cout, err_proto, err_len, in_ready} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got valid=%b sum=%h idx=%0d last=%b cout=%b ep=%b el=%b in_ready=%b, expected all 0",
                     out_valid, out_sum, out_idx, out_last, out_cout, err_proto, err_len, in_ready);
        end
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: got in_ready=%b, expected 1", in_ready);
        end
    endtask

    task automatic test_single();
        send(16'hFFFF, 16'h0001, 1, 1, 0, 1);
        @(negedge clk);
        total++;
        if ({out_valid, out_sum, out_cout, out_last, out_idx} !== {1'b1, 16'h0000, 1'b1, 1'b1, 3'd0}) begin
            bad++;
            $display("FAIL single_add: got valid=%b sum=%h cout=%b last=%b idx=%0d, expected 1 0000 1 1 0",
                     out_valid, out_sum, out_cout, out_last, out_idx);
        end
    endtask

    task automatic test_two_add();
        send(16'hFFFF, 16'h0001, 1, 0, 0, 1);
        send(16'h0000, 16'h0000, 0, 1, 0, 1);
        @(negedge clk);
        total++;
        if ({out_sum, out_idx, out_cout} !== {16'h0001, 3'd1, 1'b0}) begin
            bad++;
            $display("FAIL two_add_w2: got sum=%h idx=%0d cout=%b, expected 0001 1 0", out_sum, out_idx, out_cout);
        end
    endtask

    task automatic test_two_sub();
        send(16'h0000, 16'h0001, 1, 0, 1, 1);
        @(negedge clk);
        total++;
        if (out_sum !== 16'hFFFF) begin
            bad++;
            $display("FAIL two_sub_w1: got sum=%h, expected ffff", out_sum);
        end
        send(16'h0001, 16'h0000, 0, 1, 0, 1);
        @(negedge clk);
        total++;
        if ({out_sum, out_cout, out_last} !== {16'h0000, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL two_sub_w2: got sum=%h cout=%b last=%b, expected 0000 1 1", out_sum, out_cout, out_last);
        end
    endtask

    task automatic test_backpressure();
        send(16'h1111, 16'h2222, 1, 1, 0, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if ({out_valid, in_ready, out_sum, out_idx} !== {1'b1, 1'b0, 16'h3333, 3'd0}) begin
                bad++;
                $display("FAIL bp_hold_%0d: got valid=%b in_ready=%b sum=%h idx=%0d, expected 1 0 3333 0",
                         c, out_valid, in_ready, out_sum, out_idx);
            end
        end
        // Accept a new word in the same cycle the held one drains.
        send(16'h0001, 16'h0002, 1, 1, 0, 1);
        @(negedge clk);
        total++;
        if ({out_valid, out_sum} !== {1'b1, 16'h0003}) begin
            bad++;
            $display("FAIL bp_accept_drain: got valid=%b sum=%h, expected 1 0003", out_valid, out_sum);
        end
    endtask

    task automatic test_proto();
        send(16'h0005, 16'h0003, 1, 0, 0, 1);
        send(16'h0010, 16'h0001, 1, 1, 1, 1);
        @(negedge clk);
        total++;
        if ({err_proto, err_len, out_sum, out_idx, out_cout} !== {1'b1, 1'b0, 16'h000F, 3'd0, 1'b1}) begin
            bad++;
            $display("FAIL proto_restart: got ep=%b el=%b sum=%h idx=%0d cout=%b, expected 1 0 000f 0 1",
                     err_proto, err_len, out_sum, out_idx, out_cout);
        end
    endtask

    task automatic test_len();
        for (int w = 0; w < MAXW; w++) begin
            send(16'(w * 16'h1111), 16'hF000, (w == 0), 0, 0, 1);
        end
        @(negedge clk);
        total++;
        if ({out_last, err_len, out_idx} !== {1'b1, 1'b1, 3'd7}) begin
            bad++;
            $display("FAIL len_force: got last=%b err_len=%b idx=%0d, expected 1 1 7", out_last, err_len, out_idx);
        end
        // After the forced close, a non-first word starts a fresh operation at index 0.
        send(16'h0002, 16'h0003, 0, 1, 0, 1);
        @(negedge clk);
        total++;
        if ({out_sum, out_idx} !== {16'h0005, 3'd0}) begin
            bad++;
            $display("FAIL len_restart: got sum=%h idx=%0d, expected 0005 0", out_sum, out_idx);
        end
    endtask

    task automatic test_err_clr();
        @(posedge clk);
        #1;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        @(negedge clk);
        total++;
        if ({err_proto, err_len} !== 2'b00) begin
            bad++;
            $display("FAIL err_clr: got ep=%b el=%b, expected 0 0", err_proto, err_len);
        end
        // Clear held high across a new protocol error: the set must win.
        err_clr = 1'b1;
        send(16'h0001, 16'h0001, 1, 0, 0, 1);
        send(16'h0002, 16'h0002, 1, 1, 0, 1);
        @(negedge clk);
        total++;
        if (err_proto !== 1'b1) begin
            bad++;
            $display("FAIL err_set_wins: got ep=%b, expected 1", err_proto);
        end
        err_clr = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        send(16'hFFFF, 16'h0001, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, in_ready, err_proto} !== 3'b000) begin
            bad++;
            $display("FAIL reset_mid_op: got valid=%b in_ready=%b ep=%b, expected 0 0 0", out_valid, in_ready, err_proto);
        end
        q.delete();
        m_run = 0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        send(16'h1234, 16'h0001, 1, 1, 0, 1);
        @(negedge clk);
        total++;
        if ({out_sum, out_cout} !== {16'h1235, 1'b0}) begin
            bad++;
            $display("FAIL reset_no_stale_carry: got sum=%h cout=%b, expected 1235 0", out_sum, out_cout);
        end
    endtask

    task automatic test_drain();
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && q.size() != 0; c++) begin
            @(negedge clk);
        end
        @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d words outstanding, expected 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_add();
        test_two_sub();
        test_backpressure();
        test_proto();
        test_len();
        test_err_clr();
        test_reset_mid_op();
        test_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
